toggle_cover_collector: RTL
===========================

// Module: toggle_cover_collector
// PURPOSE
//  Synthesizable, parametrised toggle-coverage collector: watches WIDTH signal bits, detects rising and
//  falling edges per bit as separate cover points, keeps a sticky hit map and streams each newly covered
//  point once over a valid/ready port. Replaces per-bit DPI cover calls so formal/fuzz harnesses
//  (and non-DIFFTEST builds) consume toggle coverage as a hardware stream; one instance per monitored bus.
// PARAMETERS
//  WIDTH        44     number of monitored bits; 2*WIDTH cover points
//  COVER_INDEX  0      global index of this instance's first cover point
//  COVER_TOTAL  8940   global cover-point count (range check only: COVER_INDEX+2*WIDTH <= COVER_TOTAL)
//  IDX_W        32     width of rpt_index
//  CNT_W        $clog2(2*WIDTH+1)  width of hit_count
// PORTS
//  gbl_clk    in   1      clock, all state on rising edge
//  reset      in   1      synchronous, active-low reset
//  en         in   1      sample enable; 0 = sig ignored, prev value held
//  sig        in   WIDTH  monitored bits
//  clear      in   1      1-cycle pulse: forget all hits/pending, drop report in flight
//  rpt_valid  out  1      report available
//  rpt_ready  in   1      consumer accepts report
//  rpt_index  out  IDX_W  global point: COVER_INDEX+2*i (rise bit i) / COVER_INDEX+2*i+1 (fall bit i)
//  rpt_rise   out  1      1 = rising-edge point, 0 = falling
//  hit_count  out  CNT_W  number of points hit since reset/clear
//  all_hit    out  1      hit_count == 2*WIDTH
// BEHAVIOUR
//  Reset (reset==0 at edge): prev_q, primed_q, hit_q, pend_q, rpt_valid, rpt_index, rpt_rise, hit_count,
//   all_hit all 0. Reset mid-report drops the report; no handshake completes that cycle.
//  Sampling (edge with en=1): if !primed_q -> prev_q<=sig, primed_q<=1, no edges detected.
//   Else rise_i = sig[i]&~prev_q[i], fall_i = ~sig[i]&prev_q[i]; prev_q<=sig.
//   new = {rise,fall} & ~hit_q; hit_q|=new; pend_q|=new; hit_count += popcount(new) (max WIDTH per cycle,
//   no overflow possible). Re-hits of a covered point are silent.
//  Report FSM, 2 states:
//   IDLE (rpt_valid=0): if pend_q!=0 -> load lowest-indexed pending point (point order: rise0,fall0,
//    rise1,...), clear its pend bit, go HOLD.
//   HOLD (rpt_valid=1): rpt_index/rpt_rise stable until rpt_valid&rpt_ready. On handshake: if pend_q!=0
//    load next point same edge (stay HOLD, 1 report/cycle), else IDLE.
//  Encoder looks at pend_q only: a point newly set at edge k is eligible for load at edge k+1.
//  Latency: toggle sampled at edge k -> rpt_valid at earliest after edge k+1 (idle port).
//  clear=1 at edge: hit_q, pend_q, hit_count, rpt_valid <= 0, state IDLE; edges detected that same edge
//   discarded (clear wins); prev_q/primed_q still update per en. Only case rpt_valid falls without ready.
//  reset and clear together: reset wins (also clears prev_q/primed_q).
//  all_hit combinational from hit_count; rpt_* registered outputs.
// TESTING (WIDTH=4, COVER_INDEX=100, en=1, rpt_ready=1 unless stated)
//  1 reset; sig 0000 then 0001 -> rpt_valid 2 edges after change, index 100, rise=1, single beat; hit_count=1.
//  2 continue 0001->0000->0001 -> one report 101 rise=0; second rise not reported; hit_count=2.
//  3 sig 0000->1111, rpt_ready=0 5 cycles -> valid held, index 100 stable; ready=1 -> 100,102,104,106
//    on 4 consecutive cycles, then rpt_valid=0.
//  4 all bits 0->1->0 -> 8 distinct reports 100..107 each once, hit_count=8, all_hit=1; further toggles silent.
//  5 clear while rpt_valid=1 (pending non-empty) -> next cycle rpt_valid=0, hit_count=0; re-toggle bit0
//    -> 100 reported again.
//  6 reset low 1 cycle mid-HOLD, sig differs after reset -> outputs 0; first en sample only primes, no report;
//    en=0 toggles -> no reports, prev held.

Source files
------------

// File: rtl/toggle_cover_collector_if.sv
// Report stream of the toggle-coverage collector: one newly covered point per valid/ready beat.
interface toggle_cover_collector_if #(
  parameter int unsigned IDX_W = 32
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [IDX_W-1:0] rpt_index;
  logic             rpt_rise;

  modport master (output rpt_valid, rpt_index, rpt_rise, input rpt_ready);
  modport slave  (input rpt_valid, rpt_index, rpt_rise, output rpt_ready);
endinterface

// File: rtl/toggle_cover_collector.sv
// Toggle-coverage collector: per-bit rise/fall cover points, sticky hit map, and a stream
// that reports each newly covered point exactly once.
module toggle_cover_collector #(
  parameter int unsigned WIDTH       = 44,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 8940,
  parameter int unsigned IDX_W       = 32,
  parameter int unsigned CNT_W       = $clog2(2*WIDTH+1)
) (
  input  logic                        gbl_clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [WIDTH-1:0]            sig,
  input  logic                        clear,
  toggle_cover_collector_if.master    rpt,
  output logic [CNT_W-1:0]            hit_count,
  output logic                        all_hit
);
  localparam int unsigned NPT = 2*WIDTH;
  localparam int unsigned PTW = (NPT > 1) ? $clog2(NPT) : 1;

  if (COVER_INDEX + 2*WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("toggle_cover_collector: cover points exceed COVER_TOTAL");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic             primed_q;
  logic [NPT-1:0]   hit_q, pend_q;
  logic [NPT-1:0]   pts, new_pts, load_mask;
  logic [CNT_W-1:0] hit_count_q, new_cnt;
  logic [PTW-1:0]   enc_idx;
  logic             enc_any;
  logic             load;
  logic [IDX_W-1:0] rpt_index_q;
  logic             rpt_rise_q;

  // Point 2*i is the rising edge of bit i, 2*i+1 the falling edge.
  always_comb begin
    pts = '0;
    if (en && primed_q) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        pts[2*i]   = sig[i] & ~prev_q[i];
        pts[2*i+1] = ~sig[i] & prev_q[i];
      end
    end
    new_pts = pts & ~hit_q;
    new_cnt = '0;
    for (int unsigned i = 0; i < NPT; i++) begin
      new_cnt = new_cnt + CNT_W'(new_pts[i]);
    end
  end

  always_comb begin
    enc_any = 1'b0;
    enc_idx = '0;
    for (int unsigned i = 0; i < NPT; i++) begin
      if (pend_q[i] && !enc_any) begin
        enc_any = 1'b1;
        enc_idx = PTW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rpt.rpt_ready) begin
          if (enc_any) load = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    load_mask = load ? (NPT'(1) << enc_idx) : '0;
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      primed_q    <= 1'b0;
      hit_q       <= '0;
      pend_q      <= '0;
      hit_count_q <= '0;
      rpt_index_q <= '0;
      rpt_rise_q  <= 1'b0;
    end else begin
      if (en) begin
        prev_q   <= sig;
        primed_q <= 1'b1;
      end
      // Clear discards edges detected on the same edge, but sampling continues.
      if (clear) begin
        state_q     <= IDLE;
        hit_q       <= '0;
        pend_q      <= '0;
        hit_count_q <= '0;
      end else begin
        state_q     <= state_d;
        hit_q       <= hit_q | new_pts;
        pend_q      <= (pend_q & ~load_mask) | new_pts;
        hit_count_q <= hit_count_q + new_cnt;
        if (load) begin
          rpt_index_q <= IDX_W'(COVER_INDEX) + IDX_W'(enc_idx);
          rpt_rise_q  <= ~enc_idx[0];
        end
      end
    end
  end

  assign rpt.rpt_valid = (state_q == HOLD);
  assign rpt.rpt_index = rpt_index_q;
  assign rpt.rpt_rise  = rpt_rise_q;
  assign hit_count     = hit_count_q;
  assign all_hit       = (hit_count_q == CNT_W'(NPT));

endmodule
